// File: rtl/ledr_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ledr_pattern_sequencer
// Description : Avalon-MM controller that owns the red-LED PIO. The CPU
//               programs a pattern, a mode and a tick period through the
//               slave port. On every sequencer tick the block issues a
//               single-cycle write of the current pattern to the PIO. The
//               modes are alternate, rotate-left, bounce and hold.
//               This block is the PIO's only writer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   LED_W          LED / pattern width (2..32)
//   RESET_PERIOD   PERIOD reset value; tick interval is PERIOD+1 clocks
// Optional build macro:
//   LEDR_SEQ_IRQ_EN  adds the level irq output (wrap_pend & CTRL.irq_en).
//                    When this macro is undefined, CTRL[3] reads 0.
// Ports:
//   clk, reset_n      clock; asynchronous active-low reset
//   avs_*             CPU slave port: 4 registers, zero-wait combinational read
//                       0 CTRL    [0] run [2:1] mode [3] irq_en
//                       1 PERIOD  [31:0]
//                       2 PATTERN [LED_W-1:0] seed
//                       3 STATUS  rd {wrap_pend, .., cur}; wr bit31=1 clears
//   avm_*             PIO master port: single-cycle writes to address 0
//   irq               wrap interrupt (only with LEDR_SEQ_IRQ_EN)
// ============================================================================
module ledr_pattern_sequencer #(
    parameter int          LED_W        = 18,
    parameter logic [31:0] RESET_PERIOD = 32'd49_999_999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_chipselect,
    input  logic        avs_write_n,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata
`ifdef LEDR_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [1:0] {
        MODE_ALT    = 2'b00,
        MODE_ROT    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    // The longest sequence is bounce, with 2*(LED_W-1) steps.
    localparam int c_step_w = $clog2(2 * LED_W);
    localparam logic [c_step_w-1:0] c_len_alt    = c_step_w'(2);
    localparam logic [c_step_w-1:0] c_len_rot    = c_step_w'(LED_W);
    localparam logic [c_step_w-1:0] c_len_bounce = c_step_w'(2 * (LED_W - 1));

    // Register state
    logic                run_q,       run_d;
    mode_e               mode_q,      mode_d;
    logic [31:0]         period_q,    period_d;
    logic [LED_W-1:0]    pattern_q,   pattern_d;
    logic [LED_W-1:0]    cur_q,       cur_d;
    logic                dir_q,       dir_d;      // 0 = left, 1 = right
    logic [c_step_w-1:0] step_q,      step_d;
    logic [31:0]         presc_q,     presc_d;
    logic                wrap_pend_q, wrap_pend_d;
    logic                avm_cs_q,    avm_cs_d;
`ifdef LEDR_SEQ_IRQ_EN
    logic                irq_en_q,    irq_en_d;
`endif

    // Bus decode
    logic                w_wr_en;
    logic                w_wr_ctrl;
    logic                w_wr_period;
    logic                w_wr_pattern;
    logic                w_wr_status;
    logic                w_start;
    logic                w_stop_wr;
    logic                w_tick;
    logic                w_step_tick;
    logic                w_direct;
    logic [c_step_w-1:0] w_seq_len;

    assign w_wr_en      = avs_chipselect & ~avs_write_n;
    assign w_wr_ctrl    = w_wr_en & (avs_address == 2'd0);
    assign w_wr_period  = w_wr_en & (avs_address == 2'd1);
    assign w_wr_pattern = w_wr_en & (avs_address == 2'd2);
    assign w_wr_status  = w_wr_en & (avs_address == 2'd3);

    assign w_start   = w_wr_ctrl & ~run_q & avs_writedata[0];
    assign w_stop_wr = w_wr_ctrl & ~avs_writedata[0];
    // A stop written in the same cycle as a tick drops that tick.
    assign w_tick      = run_q & (presc_q >= period_q) & ~w_stop_wr;
    assign w_step_tick = w_tick & (mode_q != MODE_HOLD);
    // While stopped, PATTERN drives the LEDs directly.
    assign w_direct    = w_wr_pattern & ~run_q;

    always_comb begin
        case (mode_q)
            MODE_ALT:    w_seq_len = c_len_alt;
            MODE_ROT:    w_seq_len = c_len_rot;
            default:     w_seq_len = c_len_bounce;
        endcase
    end

    always_comb begin
        run_d       = run_q;
        mode_d      = mode_q;
        period_d    = period_q;
        pattern_d   = pattern_q;
        cur_d       = cur_q;
        dir_d       = dir_q;
        step_d      = step_q;
        wrap_pend_d = wrap_pend_q;
        avm_cs_d    = w_start | w_step_tick | w_direct;
`ifdef LEDR_SEQ_IRQ_EN
        irq_en_d    = irq_en_q;
`endif

        // Prescaler: the >= compare makes a PERIOD lowered below presc fire at once.
        if (!run_q) begin
            presc_d = 32'd0;
        end else if (presc_q >= period_q) begin
            presc_d = 32'd0;
        end else begin
            presc_d = presc_q + 32'd1;
        end

        // A status clear comes first, so a wrap in the same cycle wins below.
        if (w_wr_status && avs_writedata[31]) begin
            wrap_pend_d = 1'b0;
        end

        if (w_step_tick) begin
            case (mode_q)
                MODE_ALT: cur_d = ~cur_q;
                MODE_ROT: cur_d = {cur_q[LED_W-2:0], cur_q[LED_W-1]};
                default: begin
                    if (cur_q == '0) begin
                        cur_d = pattern_q;
                    end else if (!dir_q) begin
                        if (cur_q[LED_W-1]) begin
                            dir_d = 1'b1;
                            cur_d = cur_q >> 1;
                        end else begin
                            cur_d = cur_q << 1;
                        end
                    end else begin
                        if (cur_q[0]) begin
                            dir_d = 1'b0;
                            cur_d = cur_q << 1;
                        end else begin
                            cur_d = cur_q >> 1;
                        end
                    end
                end
            endcase

            if (step_q == w_seq_len - c_step_w'(1)) begin
                step_d      = '0;
                wrap_pend_d = 1'b1;
            end else begin
                step_d = step_q + c_step_w'(1);
            end
        end

        if (w_wr_ctrl) begin
            run_d  = avs_writedata[0];
            mode_d = mode_e'(avs_writedata[2:1]);
`ifdef LEDR_SEQ_IRQ_EN
            irq_en_d = avs_writedata[3];
`endif
            // A mode change while running restarts the step count without flagging a wrap.
            if (run_q && avs_writedata[0] && (mode_e'(avs_writedata[2:1]) != mode_q)) begin
                step_d = '0;
            end
        end

        if (w_start) begin
            cur_d   = pattern_q;
            dir_d   = 1'b0;
            step_d  = '0;
            presc_d = 32'd0;
        end

        if (w_wr_period) begin
            period_d = avs_writedata;
        end

        if (w_wr_pattern) begin
            pattern_d = avs_writedata[LED_W-1:0];
        end

        if (w_direct) begin
            cur_d = avs_writedata[LED_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q       <= 1'b0;
            mode_q      <= MODE_ALT;
            period_q    <= RESET_PERIOD;
            pattern_q   <= '0;
            cur_q       <= '0;
            dir_q       <= 1'b0;
            step_q      <= '0;
            presc_q     <= 32'd0;
            wrap_pend_q <= 1'b0;
            avm_cs_q    <= 1'b0;
`ifdef LEDR_SEQ_IRQ_EN
            irq_en_q    <= 1'b0;
`endif
        end else begin
            run_q       <= run_d;
            mode_q      <= mode_d;
            period_q    <= period_d;
            pattern_q   <= pattern_d;
            cur_q       <= cur_d;
            dir_q       <= dir_d;
            step_q      <= step_d;
            presc_q     <= presc_d;
            wrap_pend_q <= wrap_pend_d;
            avm_cs_q    <= avm_cs_d;
`ifdef LEDR_SEQ_IRQ_EN
            irq_en_q    <= irq_en_d;
`endif
        end
    end

    // Slave read mux. With LED_W=32, STATUS bit 31 is wrap_pend rather than cur[31].
    always_comb begin
        avs_readdata = '0;
        case (avs_address)
            2'd0: begin
                avs_readdata[0]   = run_q;
                avs_readdata[2:1] = mode_q;
`ifdef LEDR_SEQ_IRQ_EN
                avs_readdata[3]   = irq_en_q;
`endif
            end
            2'd1:    avs_readdata = period_q;
            2'd2:    avs_readdata[LED_W-1:0] = pattern_q;
            default: begin
                avs_readdata[LED_W-1:0] = cur_q;
                avs_readdata[31]        = wrap_pend_q;
            end
        endcase
    end

    // PIO master: cur_q already holds the value being written during the strobe cycle.
    always_comb begin
        avm_writedata            = '0;
        avm_writedata[LED_W-1:0] = cur_q;
    end

    assign avm_address    = 2'd0;
    assign avm_chipselect = avm_cs_q;
    assign avm_write_n    = ~avm_cs_q;

`ifdef LEDR_SEQ_IRQ_EN
    assign irq = wrap_pend_q & irq_en_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ledr_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ledr_pattern_sequencer
// Description : Self-checking bench for ledr_pattern_sequencer. A register
//               vector table covers reset values and register access.
//               Every expected PIO write is queued as it becomes due and
//               compared when the DUT strobes avm_chipselect. Hand-written
//               sequences cover rotate, alternate, bounce, stop-on-tick,
//               irq and reset mid-run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ledr_pattern_sequencer;

    localparam logic [1:0] A_CTRL = 2'd0, A_PERIOD = 2'd1, A_PATTERN = 2'd2, A_STATUS = 2'd3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  avs_address;
    logic        avs_chipselect;
    logic        avs_write_n;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
`ifdef LEDR_SEQ_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    ledr_pattern_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .avs_address    (avs_address),
        .avs_chipselect (avs_chipselect),
        .avs_write_n    (avs_write_n),
        .avs_writedata  (avs_writedata),
        .avs_readdata   (avs_readdata),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata)
`ifdef LEDR_SEQ_IRQ_EN
        ,
        .irq            (irq)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit sb_en  = 1'b1;
    int cyc    = 0;
    int last_wr = 0;

    // Expected PIO write; gap = required cycles since the previous write (0 = any).
    typedef struct {
        logic [31:0] data;
        int          gap;
    } pio_t;
    pio_t exp_q[$];

    typedef struct {
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;   // read: expected readdata; write: expected PIO data if pio
        bit          pio;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every PIO strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset_n && sb_en && avm_chipselect) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pio_unexpected actual=0x%08h required=no_write", avm_writedata);
            end else begin
                check("pio_data", avm_writedata, exp_q[0].data);
                check("pio_strobe", {29'd0, avm_address, avm_write_n}, 32'h0);
                if (exp_q[0].gap != 0)
                    check("pio_gap", 32'(cyc - last_wr), 32'(exp_q[0].gap));
                exp_q.delete(0);
            end
            last_wr <= cyc;
        end
    end

    function automatic void push(input logic [31:0] d, input int gap);
        pio_t e;
        e.data = d;
        e.gap  = gap;
        exp_q.push_back(e);
    endfunction

    // All bus tasks start and end at posedge+1.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        avs_address    = a;
        avs_writedata  = d;
        avs_chipselect = 1'b1;
        avs_write_n    = 1'b0;
        @(posedge clk); #1;
        avs_chipselect = 1'b0;
        avs_write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        avs_address    = a;
        avs_chipselect = 1'b1;
        avs_write_n    = 1'b1;
        #2;
        d = avs_readdata;
        @(posedge clk); #1;
        avs_chipselect = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] req);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, req);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_q(input int target, input int limit);
        int n = 0;
        while (exp_q.size() != target && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("queue_drain", 32'(exp_q.size()), 32'(target));
    endtask

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{0, A_CTRL,    32'h0,          32'h0,          0};
        vecs[1]  = '{0, A_PERIOD,  32'h0,          32'd49_999_999, 0};
        vecs[2]  = '{0, A_PATTERN, 32'h0,          32'h0,          0};
        vecs[3]  = '{0, A_STATUS,  32'h0,          32'h0,          0};
        vecs[4]  = '{1, A_PATTERN, 32'h0002_AAAA,  32'h0002_AAAA,  1};
        vecs[5]  = '{0, A_STATUS,  32'h0,          32'h0002_AAAA,  0};
        vecs[6]  = '{0, A_PATTERN, 32'h0,          32'h0002_AAAA,  0};
        vecs[7]  = '{1, A_PERIOD,  32'h1234_5678,  32'h0,          0};
        vecs[8]  = '{0, A_PERIOD,  32'h0,          32'h1234_5678,  0};
        vecs[9]  = '{1, A_CTRL,    32'h0000_000E,  32'h0,          0};
`ifdef LEDR_SEQ_IRQ_EN
        vecs[10] = '{0, A_CTRL,    32'h0,          32'h0000_000E,  0};
`else
        vecs[10] = '{0, A_CTRL,    32'h0,          32'h0000_0006,  0};
`endif
        vecs[11] = '{1, A_PATTERN, 32'hFFFF_FFFF,  32'h0003_FFFF,  1};
        vecs[12] = '{0, A_STATUS,  32'h0,          32'h0003_FFFF,  0};
        vecs[13] = '{0, A_PATTERN, 32'h0,          32'h0003_FFFF,  0};
        vecs[14] = '{1, A_CTRL,    32'h0,          32'h0,          0};

        reset_n        = 1'b0;
        avs_address    = 2'd0;
        avs_chipselect = 1'b0;
        avs_write_n    = 1'b1;
        avs_writedata  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_avm_cs", {31'd0, avm_chipselect}, 32'h0);
        check("reset_avm_wn", {31'd0, avm_write_n}, 32'h1);
        check("reset_avm_wd", avm_writedata, 32'h0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Register table
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) begin
                if (vecs[i].pio) push(vecs[i].exp, 0);
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                read_check($sformatf("vec%0d_read", i), vecs[i].addr, vecs[i].exp);
            end
        end
        wait_q(0, 20);

        // Rotate, PERIOD=3: writes 4 clocks apart, wrap after 18 ticks
        bus_write(A_PERIOD, 32'd3);
        push(32'h1, 0);
        bus_write(A_PATTERN, 32'h1);
        push(32'h1, 0);
        bus_write(A_CTRL, 32'h3);
        for (int k = 1; k <= 18; k++) push(32'h1 << (k % 18), 4);
        wait_q(1, 200);
        read_check("rot_status_prewrap", A_STATUS, 32'h0002_0000);
        wait_q(0, 20);
        bus_write(A_CTRL, 32'h2);
        read_check("rot_status_wrap", A_STATUS, 32'h8000_0001);
        bus_write(A_STATUS, 32'h8000_0000);
        read_check("rot_status_clr", A_STATUS, 32'h0000_0001);
        idle(8);

        // Alternate, PERIOD=0: writes every clock; stop lands on a tick
        bus_write(A_PERIOD, 32'd0);
        push(32'h0000_0F0F, 0);
        bus_write(A_PATTERN, 32'h0000_0F0F);
        push(32'h0000_0F0F, 0);
        bus_write(A_CTRL, 32'h1);
        for (int k = 1; k <= 5; k++) push((k % 2) ? 32'h0003_F0F0 : 32'h0000_0F0F, 1);
        wait_q(1, 50);
        bus_write(A_CTRL, 32'h0);
        wait_q(0, 10);
        idle(4);
        read_check("alt_status", A_STATUS, 32'h8003_F0F0);
        bus_write(A_STATUS, 32'h8000_0000);
        read_check("alt_status_clr", A_STATUS, 32'h0003_F0F0);

        // Bounce, PERIOD=1: walk right to bit 0, reverse, then stop on the tick
        bus_write(A_PERIOD, 32'd1);
        push(32'h0002_0000, 0);
        bus_write(A_PATTERN, 32'h0002_0000);
        push(32'h0002_0000, 0);
        bus_write(A_CTRL, 32'h5);
        for (int k = 1; k <= 17; k++) push(32'h0002_0000 >> k, 2);
        push(32'h0000_0002, 2);
        wait_q(0, 200);
        bus_write(A_CTRL, 32'h4);
        idle(6);
        read_check("bounce_status_held", A_STATUS, 32'h0000_0002);
        read_check("bounce_ctrl", A_CTRL, 32'h0000_0004);

`ifdef LEDR_SEQ_IRQ_EN
        begin
            int n = 0;
            sb_en = 1'b0;
            bus_write(A_PERIOD, 32'd0);
            bus_write(A_PATTERN, 32'h1);
            check("irq_idle", {31'd0, irq}, 32'h0);
            bus_write(A_CTRL, 32'hB);
            while (!irq && n < 100) begin @(posedge clk); #1; n++; end
            check("irq_wrap", {31'd0, irq}, 32'h1);
            bus_write(A_CTRL, 32'hA);
            bus_write(A_STATUS, 32'h8000_0000);
            check("irq_cleared", {31'd0, irq}, 32'h0);
            bus_write(A_CTRL, 32'hB);
            idle(17);
            check("irq_before_wrap", {31'd0, irq}, 32'h0);
            bus_write(A_STATUS, 32'h8000_0000);
            check("irq_wrap_beats_clear", {31'd0, irq}, 32'h1);
            bus_write(A_CTRL, 32'hA);
            bus_write(A_STATUS, 32'h8000_0000);
            idle(2);
            sb_en = 1'b1;
        end
`endif

        // Reset mid-run
        sb_en = 1'b0;
        bus_write(A_PERIOD, 32'd0);
        bus_write(A_CTRL, 32'h3);
        idle(4);
        check("prereset_running_cs", {31'd0, avm_chipselect}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("midrun_reset_cs", {31'd0, avm_chipselect}, 32'h0);
        check("midrun_reset_wn", {31'd0, avm_write_n}, 32'h1);
        check("midrun_reset_wd", avm_writedata, 32'h0);
        idle(2);
        @(negedge clk) reset_n = 1'b1;
        exp_q.delete();
        sb_en = 1'b1;
        @(posedge clk); #1;
        read_check("post_reset_status", A_STATUS, 32'h0);
        read_check("post_reset_period", A_PERIOD, 32'd49_999_999);
        read_check("post_reset_ctrl", A_CTRL, 32'h0);
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
